// File: rtl/boot_spi_loader_if.sv
// boot_spi_loader_if: RAM-side bus and status of the boot SPI loader.
// Signals: ram_we/ram_waddr/ram_wdat (write port), ram_raddr/ram_rdat (read-back port),
// busy (frame open), load_done (frame with writes ended).
// slave modport is the loader; master modport is the RAM/system side.
interface boot_spi_loader_if #(
  parameter int ADDR_W = 10
);
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [7:0]        ram_wdat;
  logic [ADDR_W-1:0] ram_raddr;
  logic [7:0]        ram_rdat;
  logic              busy;
  logic              load_done;
  modport master (input ram_we, ram_waddr, ram_wdat, ram_raddr, busy, load_done, output ram_rdat);
  modport slave  (output ram_we, ram_waddr, ram_wdat, ram_raddr, busy, load_done, input ram_rdat);
endinterface

// File: rtl/boot_spi_loader.sv
// boot_spi_loader: SPI mode-0 slave that writes the boot image into the boot RAM.
// Ports: clk, rst_n (async active-low), spi_ss/spi_clk/spi_mosi (async SPI inputs),
// spi_miso (tri-state read-back data), bus (boot_spi_loader_if.slave: RAM ports, busy, load_done).
// Frame: cmd, addr_hi, addr_lo, payload. 0xA5 = write, 0x5A = read (BOOT_SPI_READBACK_EN only).
// Optional feature macro: BOOT_SPI_READBACK_EN enables read-back over spi_miso.
module boot_spi_loader #(
  parameter int ADDR_W      = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             spi_ss,
  input  logic             spi_clk,
  input  logic             spi_mosi,
  output wire              spi_miso,
  boot_spi_loader_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CMD, ADDR_HI, ADDR_LO, WDATA, DUMMY, RDATA, IGNORE} state_t;
  state_t                 state_q;
  logic [SYNC_STAGES-1:0] ss_sync_q, sck_sync_q, mosi_sync_q;
  logic                   ss_prev_q, sck_prev_q, armed_q;
  logic [2:0]             bit_q;
  logic [7:0]             rx_q, byte_q;
  logic                   done_q, wrote_q;
  logic [ADDR_W-1:0]      addr_q, ram_waddr_q;
  logic                   ram_we_q;
  logic [7:0]             ram_wdat_q;
  logic                   ss_s, sck_s, mosi_s, rise, ss_fall;
  logic [7:0]             rx_d;
  assign ss_s    = ss_sync_q[SYNC_STAGES-1];
  assign sck_s   = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s  = mosi_sync_q[SYNC_STAGES-1];
  assign rise    = sck_s & ~sck_prev_q;
  // ss_prev_q resets low, so a frame only starts after slave select has been seen high;
  // a frame already open when reset releases is never joined.
  assign ss_fall = ss_prev_q & ~ss_s;
  assign rx_d    = {rx_q[6:0], mosi_s};
  assign bus.busy      = armed_q & ~ss_s;
  assign bus.load_done = ss_s & ~ss_prev_q & wrote_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_waddr = ram_waddr_q;
  assign bus.ram_wdat  = ram_wdat_q;
`ifdef BOOT_SPI_READBACK_EN
  logic              rd_q, miso_q, fall;
  logic [7:0]        tx_q;
  logic [1:0]        ld_q;
  logic [ADDR_W-1:0] ram_raddr_q;
  assign fall          = ~sck_s & sck_prev_q;
  assign spi_miso      = bus.busy ? miso_q : 1'bz;
  assign bus.ram_raddr = ram_raddr_q;
`else
  logic unused_rdat;
  assign unused_rdat   = ^bus.ram_rdat;
  assign spi_miso      = 1'bz;
  assign bus.ram_raddr = '0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_sync_q   <= '0;
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      ss_prev_q   <= 1'b0;
      sck_prev_q  <= 1'b0;
      armed_q     <= 1'b0;
      state_q     <= IDLE;
      bit_q       <= '0;
      rx_q        <= '0;
      byte_q      <= '0;
      done_q      <= 1'b0;
      wrote_q     <= 1'b0;
      addr_q      <= '0;
      ram_we_q    <= 1'b0;
      ram_waddr_q <= '0;
      ram_wdat_q  <= '0;
`ifdef BOOT_SPI_READBACK_EN
      rd_q        <= 1'b0;
      miso_q      <= 1'b0;
      tx_q        <= '0;
      ld_q        <= '0;
      ram_raddr_q <= '0;
`endif
    end else begin
      ss_sync_q   <= SYNC_STAGES'({ss_sync_q, spi_ss});
      sck_sync_q  <= SYNC_STAGES'({sck_sync_q, spi_clk});
      mosi_sync_q <= SYNC_STAGES'({mosi_sync_q, spi_mosi});
      ss_prev_q   <= ss_s;
      sck_prev_q  <= sck_s;
      armed_q     <= armed_q | ss_s;
      ram_we_q    <= 1'b0;
      done_q      <= 1'b0;
`ifdef BOOT_SPI_READBACK_EN
      // ld_q delays the tx load until ram_rdat reflects the new ram_raddr
      ld_q <= {ld_q[0], 1'b0};
      if (fall) begin
        miso_q <= tx_q[7];
        tx_q   <= {tx_q[6:0], 1'b0};
      end
      if (ld_q[1]) tx_q <= bus.ram_rdat;
`endif
      if (ss_s) begin
        state_q <= IDLE;
        bit_q   <= '0;
        wrote_q <= 1'b0;
`ifdef BOOT_SPI_READBACK_EN
        miso_q  <= 1'b0;
        tx_q    <= '0;
        ld_q    <= '0;
`endif
      end else if (state_q == IDLE) begin
        if (ss_fall) state_q <= CMD;
      end else begin
        if (rise) begin
          rx_q  <= rx_d;
          bit_q <= bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            done_q <= 1'b1;
            byte_q <= rx_d;
          end
        end
        // completed bytes are acted on one cycle later, from byte_q
        if (done_q)
          case (state_q)
            CMD: begin
`ifdef BOOT_SPI_READBACK_EN
              rd_q    <= byte_q == 8'h5A;
              state_q <= (byte_q == 8'hA5 || byte_q == 8'h5A) ? ADDR_HI : IGNORE;
`else
              state_q <= byte_q == 8'hA5 ? ADDR_HI : IGNORE;
`endif
            end
            ADDR_HI: begin
              addr_q  <= ADDR_W'({byte_q, 8'h00});
              state_q <= ADDR_LO;
            end
            ADDR_LO: begin
              addr_q  <= {addr_q[ADDR_W-1:8], byte_q};
`ifdef BOOT_SPI_READBACK_EN
              state_q <= rd_q ? DUMMY : WDATA;
`else
              state_q <= WDATA;
`endif
            end
            WDATA: begin
              ram_we_q    <= 1'b1;
              ram_waddr_q <= addr_q;
              ram_wdat_q  <= byte_q;
              addr_q      <= addr_q + ADDR_W'(1);
              wrote_q     <= 1'b1;
            end
`ifdef BOOT_SPI_READBACK_EN
            DUMMY, RDATA: begin
              state_q     <= RDATA;
              ram_raddr_q <= addr_q;
              addr_q      <= addr_q + ADDR_W'(1);
              ld_q        <= 2'b01;
            end
`endif
            default: ;
          endcase
      end
    end
  end
endmodule

// File: tb/tb_boot_spi_loader.sv
// tb_boot_spi_loader: randomized and directed SPI frames checked against a frame-level reference model.
module tb_boot_spi_loader;
  localparam int AW = 10;
  localparam int SS = 2;
  localparam int HP = 8;
  logic clk = 1'b0, rst_n = 1'b0, spi_ss = 1'b1, spi_clk = 1'b0, spi_mosi = 1'b0;
  wire  spi_miso;
  boot_spi_loader_if #(.ADDR_W(AW)) bus();
  boot_spi_loader #(.ADDR_W(AW), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst_n(rst_n), .spi_ss(spi_ss), .spi_clk(spi_clk),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .bus(bus)
  );
  always #5 clk = ~clk;
  logic [7:0] ram [1024];
  logic [7:0] ref_mem [1024];
  int  n_chk = 0, n_fail = 0, n_ld = 0;
  int  wq_a[$], wq_d[$];
  logic prev_busy = 1'b0;
  time last_rise = 0;
  task automatic chk(input string tag, input int got, input int want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask
  always @(posedge clk) begin
    if (bus.ram_we) ram[bus.ram_waddr] = bus.ram_wdat;
    bus.ram_rdat <= ram[bus.ram_raddr];
  end
  always @(negedge clk) begin
    if (bus.ram_we) begin
      wq_a.push_back(int'(bus.ram_waddr));
      wq_d.push_back(int'(bus.ram_wdat));
      chk("write_latency", int'(($time - last_rise) / 10), SS + 2);
    end
    if (bus.load_done) begin
      n_ld++;
      chk("load_done_on_busy_fall", {prev_busy, bus.busy}, 2'b10);
    end
    prev_busy = bus.busy;
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic xfer(input logic [7:0] b, input int nb, output logic [7:0] r);
    r = '0;
    for (int i = 0; i < nb; i++) begin
      spi_mosi = b[7-i];
      tick(HP);
      spi_clk   = 1'b1;
      last_rise = $time;
      r = {r[6:0], spi_miso};
      tick(HP);
      spi_clk = 1'b0;
    end
  endtask
  task automatic run_frame(input logic [63:0] v, input int n, input int cut);
    logic [7:0] f [8];
    logic [7:0] got [8];
    logic [7:0] r;
    int a, np, ld0;
    for (int i = 0; i < 8; i++) begin
      f[i]   = v[63-8*i -: 8];
      got[i] = '0;
    end
    wq_a.delete();
    wq_d.delete();
    ld0 = n_ld;
    spi_ss = 1'b0;
    tick(2*HP);
    for (int i = 0; i < n; i++) begin
      xfer(f[i], 8, r);
      got[i] = r;
    end
    if (cut > 0) xfer(8'($urandom), cut, r);
    chk("busy_in_frame", int'(bus.busy), 1);
    tick(HP);
    spi_ss = 1'b1;
    tick(4*HP);
    chk("busy_after_frame", int'(bus.busy), 0);
    a  = n >= 3 ? int'({f[1][1:0], f[2]}) : 0;
    np = (n > 3 && f[0] == 8'hA5) ? n - 3 : 0;
    chk("write_count", wq_a.size(), np);
    for (int k = 0; k < np; k++) begin
      ref_mem[(a+k)%1024] = f[3+k];
      if (k < wq_a.size()) begin
        chk("write_addr", wq_a[k], (a+k)%1024);
        chk("write_data", wq_d[k], int'(f[3+k]));
      end
    end
    chk("load_done_count", n_ld - ld0, np > 0 ? 1 : 0);
    if (np > 0) begin
      chk("waddr_hold", int'(bus.ram_waddr), (a+np-1)%1024);
      chk("wdat_hold", int'(bus.ram_wdat), int'(f[n-1]));
    end
`ifdef BOOT_SPI_READBACK_EN
    if (n > 0 && f[0] == 8'h5A)
      for (int i = 0; i < n; i++)
        chk("miso_byte", int'(got[i]), i < 4 ? 0 : int'(ref_mem[(a+i-4)%1024]));
`endif
  endtask
  initial begin
    logic [7:0] r;
    int ld0;
    for (int i = 0; i < 1024; i++) begin
      ram[i]     = 8'($urandom);
      ref_mem[i] = ram[i];
    end
    tick(4);
    chk("reset_ram_we", int'(bus.ram_we), 0);
    chk("reset_ram_waddr", int'(bus.ram_waddr), 0);
    chk("reset_ram_wdat", int'(bus.ram_wdat), 0);
    chk("reset_ram_raddr", int'(bus.ram_raddr), 0);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_load_done", int'(bus.load_done), 0);
    rst_n = 1'b1;
    tick(10);
    run_frame(64'hA5_00_10_11_22_33_00_00, 6, 0);
    run_frame(64'hA5_03_FF_AA_BB_00_00_00, 5, 0);
    run_frame(64'hA5_FF_FE_01_02_03_00_00, 6, 0);
    run_frame(64'hA5_00_00_00_00_00_00_00, 3, 5);
    run_frame(64'hA5_00_00_7E_00_00_00_00, 4, 0);
    run_frame(64'h3C_00_00_55_00_00_00_00, 4, 0);
    run_frame(64'hA5_00_20_00_00_00_00_00, 3, 0);
    ram[256] = 8'hDE; ref_mem[256] = 8'hDE;
    ram[257] = 8'hAD; ref_mem[257] = 8'hAD;
    run_frame(64'h5A_01_00_00_00_00_00_00, 6, 0);
    ld0 = n_ld;
    spi_ss = 1'b0;
    tick(2*HP);
    xfer(8'hA5, 8, r);
    xfer(8'h00, 8, r);
    xfer(8'h20, 8, r);
    wq_a.delete();
    wq_d.delete();
    xfer(8'hC3, 4, r);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ram_we", int'(bus.ram_we), 0);
    chk("midrst_ram_waddr", int'(bus.ram_waddr), 0);
    chk("midrst_ram_wdat", int'(bus.ram_wdat), 0);
    chk("midrst_ram_raddr", int'(bus.ram_raddr), 0);
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_load_done", int'(bus.load_done), 0);
    tick(3);
    rst_n = 1'b1;
    xfer(8'h3C, 4, r);
    xfer(8'h99, 8, r);
    chk("midrst_stays_idle", int'(bus.busy), 0);
    tick(HP);
    spi_ss = 1'b1;
    tick(4*HP);
    chk("midrst_no_write", wq_a.size(), 0);
    chk("midrst_no_load_done", n_ld - ld0, 0);
    run_frame(64'hA5_01_23_45_67_00_00_00, 5, 0);
    for (int t = 0; t < 30; t++) begin
      logic [63:0] v;
      int sel;
      sel = $urandom_range(0, 9);
      v   = {$urandom, $urandom};
      v[63:56] = sel < 6 ? 8'hA5 : sel < 8 ? 8'h5A : v[63:56];
      run_frame(v, $urandom_range(1, 8), $urandom_range(0, 3) == 0 ? $urandom_range(1, 7) : 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
